// File: rtl/camellia_fl_layer_pipe.sv
// Two-stage pipelined Camellia FL / FL^-1 layer over LANES 128-bit blocks with valid/ready flow control.
// Optional per-transfer pass-through is compiled in with `define CAMELLIA_FL_BYPASS_EN (adds port in_bypass).
module camellia_fl_layer_pipe #(
    parameter int LANES = 1,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*128-1:0]   din,
    input  logic [63:0]            kl_a,
    input  logic [63:0]            kl_b,
    input  logic                   dec,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef CAMELLIA_FL_BYPASS_EN
    input  logic                   in_bypass,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*128-1:0]   dout,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int W = LANES * 128;

    function automatic logic [31:0] rol1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    // Lane layout after S1: {FL xL, FL yR, FL^-1 xL', FL^-1 yR}.
    function automatic logic [127:0] lane_s1(input logic [127:0] x,
                                             input logic [31:0]  fl_kl,
                                             input logic [31:0]  inv_kr);
        logic [31:0] fl_yr;
        logic [31:0] inv_xl;
        fl_yr  = x[95:64] ^ rol1(x[127:96] & fl_kl);
        inv_xl = x[63:32] ^ (x[31:0] | inv_kr);
        return {x[127:96], fl_yr, inv_xl, x[31:0]};
    endfunction

    function automatic logic [127:0] lane_s2(input logic [127:0] s,
                                             input logic [31:0]  fl_kr,
                                             input logic [31:0]  inv_kl);
        logic [31:0] fl_yl;
        logic [31:0] inv_xr;
        fl_yl  = s[127:96] ^ (s[95:64] | fl_kr);
        inv_xr = s[31:0] ^ rol1(s[63:32] & inv_kl);
        return {fl_yl, s[95:64], s[63:32], inv_xr};
    endfunction

    logic             r_s1_valid;
    logic [W-1:0]     r_s1_data;
    logic [31:0]      r_s1_fl_kr;
    logic [31:0]      r_s1_inv_kl;
    logic [TAG_W-1:0] r_s1_tag;
    logic             r_s1_byp;

    logic             r_s2_valid;
    logic [W-1:0]     r_dout;
    logic [TAG_W-1:0] r_out_tag;

    logic             w_out_valid;
    logic             w_out_fire;
    logic             w_s2_load;
    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_bypass;
    logic [63:0]      w_k_fl;
    logic [63:0]      w_k_inv;
    logic [W-1:0]     w_s1_next;
    logic [W-1:0]     w_s2_next;

`ifdef CAMELLIA_FL_BYPASS_EN
    assign w_bypass = in_bypass;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_k_fl  = dec ? kl_b : kl_a;
    assign w_k_inv = dec ? kl_a : kl_b;

    // Handshake is masked while RST is low so nothing is emitted or counted as accepted during reset.
    assign w_out_valid = r_s2_valid & RST;
    assign w_out_fire  = w_out_valid & out_ready;
    assign w_s2_load   = r_s1_valid & (~r_s2_valid | w_out_fire);
    assign w_in_ready  = ~RST | ~r_s1_valid | w_s2_load;
    assign w_in_fire   = in_valid & w_in_ready & RST;

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_s1_next = '0;
        for (int n = 0; n < LANES; n++) begin
            w_s1_next[n*128 +: 128] = lane_s1(din[n*128 +: 128], w_k_fl[63:32], w_k_inv[31:0]);
        end
        if (w_bypass) begin
            w_s1_next = din;
        end
    end

    always_comb begin
        w_s2_next = '0;
        for (int n = 0; n < LANES; n++) begin
            w_s2_next[n*128 +: 128] = lane_s2(r_s1_data[n*128 +: 128], r_s1_fl_kr, r_s1_inv_kl);
        end
        if (r_s1_byp) begin
            w_s2_next = r_s1_data;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_dout     <= '0;
            r_out_tag  <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_dout     <= w_s2_next;
                r_out_tag  <= r_s1_tag;
            end else if (w_out_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // NOTE: S1 payload is only consumed when r_s1_valid is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_data   <= w_s1_next;
            r_s1_fl_kr  <= w_k_fl[31:0];
            r_s1_inv_kl <= w_k_inv[63:32];
            r_s1_tag    <= in_tag;
            r_s1_byp    <= w_bypass;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign dout      = r_dout;
    assign out_tag   = r_out_tag;

endmodule
